// File: rtl/mesh_wrapper.sv
// Generic circular FIFO: head is shown combinationally from storage, one cycle from write to visible.
// A push is accepted when not full, or when a pop frees the head on the same edge.
module mesh_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign rd_vld = (cnt_q != '0);
  assign full   = (cnt_q == FULL_CNT);
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_rdy && rd_vld;
    do_wr    = wr_vld && (!full || do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// 16-terminal crossbar standing in for the 4x4 mesh: pop is combinational with the grant, pndng rises one cycle later.
// A source whose target FIFO(s) are full stays pending while the round-robin keeps serving everyone else.
module mesh_wrapper #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] broadcast  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           pndng_i_in,
  input  logic [16*pckg_sz-1:0] data_out_i_in,
  output logic [15:0]           pop,
  output logic [15:0]           pndng,
  output logic [16*pckg_sz-1:0] data_out,
  input  logic [15:0]           popin
);
  // Terminals sit around the 6x6 grid border: top row, left column, bottom row, right column.
  function automatic logic [7:0] term_id(input logic [3:0] t);
    logic [3:0] lane;
    lane = {2'b00, t[1:0]} + 4'd1;
    case (t[3:2])
      2'd0:    term_id = {4'd0, lane};
      2'd1:    term_id = {lane, 4'd0};
      2'd2:    term_id = {4'd5, lane};
      default: term_id = {lane, 4'd5};
    endcase
  endfunction

  logic [7:0]         dst      [16];
  logic [15:0]        tgt_mask [16];
  logic [15:0]        eligible;
  logic [15:0]        fifo_full;
  logic [15:0]        wr_vld;
  logic [pckg_sz-1:0] wr_dat;
  logic [3:0]         last_grant_q, last_grant_d;
  logic [3:0]         grant_idx, cand;
  logic               grant_vld;

  // An invalid destination yields an empty mask, so it is always eligible and simply dropped.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 16; i++) begin
      dst[i]      = data_out_i_in[i*pckg_sz + pckg_sz - 8 +: 8];
      tgt_mask[i] = '0;
      if (dst[i] == broadcast) begin
        tgt_mask[i] = ~(16'b1 << i);
      end else begin
        for (int t = 0; t < 16; t++) begin
          if (dst[i] == term_id(4'(t))) begin
            tgt_mask[i][t] = 1'b1;
          end
        end
      end
      eligible[i] = pndng_i_in[i] && ((tgt_mask[i] & fifo_full) == '0);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= 16; k++) begin
      cand = last_grant_q + 4'(k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    last_grant_d = grant_vld ? grant_idx : last_grant_q;
    pop    = '0;
    wr_vld = '0;
    wr_dat = data_out_i_in[grant_idx*pckg_sz +: pckg_sz];
    if (grant_vld && !reset) begin
      pop[grant_idx] = 1'b1;
      wr_vld         = tgt_mask[grant_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 4'hF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  for (genvar t = 0; t < 16; t++) begin : g_out
    mesh_fifo #(
      .W     (pckg_sz),
      .DEPTH (fifo_depth)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (wr_vld[t]),
      .wr_dat (wr_dat),
      .rd_rdy (popin[t]),
      .rd_vld (pndng[t]),
      .rd_dat (data_out[t*pckg_sz +: pckg_sz]),
      .full   (fifo_full[t])
    );
  end
endmodule

// File: tb/tb_mesh_wrapper.sv
// Bench for mesh_wrapper: directed scenarios plus randomized traffic against a per-pair ordering scoreboard.
module tb_mesh_wrapper;
  localparam int W = 40;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [15:0]      pndng_i_in = '0;
  logic [16*W-1:0]  data_out_i_in = '0;
  logic [15:0]      pop, pndng;
  logic [16*W-1:0]  data_out;
  logic [15:0]      popin = '0;
  logic [15:0]      pop_seen = '0;
  bit               rand_popin = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;

  typedef struct packed {
    logic [3:0]   dst;
    logic [W-1:0] pkt;
  } exp_t;

  logic [W-1:0] src_q [16][$];
  exp_t         sb [$];

  mesh_wrapper #(
    .pckg_sz    (W),
    .fifo_depth (4),
    .broadcast  (8'hFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .pop           (pop),
    .pndng         (pndng),
    .data_out      (data_out),
    .popin         (popin)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference terminal map, from the grid-border rules.
  function automatic logic [7:0] term_byte(input int t);
    if (t < 4)       return {4'd0, 4'(t + 1)};
    else if (t < 8)  return {4'(t - 3), 4'd0};
    else if (t < 12) return {4'd5, 4'(t - 7)};
    else             return {4'(t - 11), 4'd5};
  endfunction

  function automatic int dec(input logic [7:0] b);
    int r, c;
    r = int'(b[7:4]);
    c = int'(b[3:0]);
    if (r == 0 && c >= 1 && c <= 4) return c - 1;
    if (c == 0 && r >= 1 && r <= 4) return 3 + r;
    if (r == 5 && c >= 1 && c <= 4) return 7 + c;
    if (c == 5 && r >= 1 && r <= 4) return 11 + r;
    return -1;
  endfunction

  task automatic refresh_inputs();
    for (int i = 0; i < 16; i++) begin
      pndng_i_in[i] = (src_q[i].size() > 0);
      data_out_i_in[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic push_exp(input int t, input logic [W-1:0] pkt);
    exp_t e;
    e.dst = 4'(t);
    e.pkt = pkt;
    sb.push_back(e);
  endtask

  // Low nibble of every packet carries its source so the monitor can match per-pair order.
  task automatic send(input int s, input logic [7:0] d, output logic [W-1:0] pkt);
    int t;
    pkt = {d, 28'($urandom), 4'(s)};
    src_q[s].push_back(pkt);
    if (d == 8'hFF) begin
      for (int k = 0; k < 16; k++) if (k != s) push_exp(k, pkt);
    end else begin
      t = dec(d);
      if (t >= 0) push_exp(t, pkt);
    end
    refresh_inputs();
  endtask

  task automatic sb_check(input int t, input logic [W-1:0] d);
    int idx;
    idx = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (idx < 0 && sb[k].dst == 4'(t) && sb[k].pkt[3:0] == d[3:0]) idx = k;
    end
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: terminal %0d delivered %0h, required nothing", t, d);
    end else begin
      check($sformatf("sb_data_t%0d", t), 64'(d), 64'(sb[idx].pkt));
      sb.delete(idx);
    end
  endtask

  function automatic bit srcs_busy();
    for (int i = 0; i < 16; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pop_seen = '0;
    end else begin
      pop_seen = pop;
      check("pop_onehot0", 64'($onehot0(pop)), 64'd1);
      check("pop_without_pending", 64'(pop & ~pndng_i_in), 64'd0);
      for (int t = 0; t < 16; t++) begin
        if (popin[t] && pndng[t]) sb_check(t, data_out[t*W +: W]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        if (pop_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
    end
    if (rand_popin) popin = 16'($urandom);
    refresh_inputs();
  end

  task automatic at_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    popin = '0;
    for (int i = 0; i < 16; i++) src_q[i].delete();
    sb.delete();
    refresh_inputs();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] pkt, pkt2;
    int cyc;
    int order [3];
    order = '{2, 5, 9};

    #1;
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_pndng", 64'(pndng), 64'd0);
    check("rst_data_out", 64'(|data_out), 64'd0);
    reset_dut();
    at_neg();
    check("post_rst_pndng", 64'(pndng), 64'd0);

    // Unicast terminal 0 -> terminal 7 (row 4, col 0)
    at_pos();
    send(0, 8'h40, pkt);
    at_neg();
    check("uni_pop", 64'(pop), 64'h0001);
    check("uni_pndng_early", 64'(pndng[7]), 64'd0);
    at_neg();
    check("uni_pop_after", 64'(pop), 64'd0);
    check("uni_pndng", 64'(pndng), 64'h0080);
    check("uni_data", 64'(data_out[7*W +: W]), 64'(pkt));
    at_pos();
    popin = 16'h0080;
    at_pos();
    popin = '0;
    at_neg();
    check("uni_cleared", 64'(pndng), 64'd0);

    // Broadcast from terminal 3
    at_pos();
    send(3, 8'hFF, pkt);
    at_neg();
    check("bc_pop", 64'(pop), 64'h0008);
    at_neg();
    check("bc_pndng", 64'(pndng), 64'hFFF7);
    for (int t = 0; t < 16; t++) begin
      if (t != 3) check($sformatf("bc_data_t%0d", t), 64'(data_out[t*W +: W]), 64'(pkt));
    end
    at_pos();
    popin = 16'hFFFF;
    at_pos();
    popin = '0;
    at_neg();
    check("bc_cleared", 64'(pndng), 64'd0);

    // Round-robin from reset: 2, 5, 9 all to terminal 12
    reset_dut();
    at_pos();
    send(2, 8'h15, pkt);
    send(5, 8'h15, pkt);
    send(9, 8'h15, pkt);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check($sformatf("arb_pop_%0d", k), 64'(pop), 64'(16'b1 << order[k]));
    end
    at_neg();
    check("arb_idle", 64'(pop), 64'd0);
    at_pos();
    popin = 16'h1000;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check($sformatf("arb_fifo_order_%0d", k), 64'(data_out[12*W +: 4]), 64'(order[k]));
    end
    at_pos();
    popin = '0;
    at_neg();
    check("arb_cleared", 64'(pndng), 64'd0);

    // Full FIFO and backpressure: five packets from terminal 1 to terminal 0
    at_pos();
    for (int k = 0; k < 5; k++) send(1, 8'h01, pkt);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check($sformatf("full_accept_%0d", k), 64'(pop), 64'h0002);
    end
    at_neg();
    check("full_blocked", 64'(pop), 64'd0);
    check("full_pndng", 64'(pndng[0]), 64'd1);
    at_pos();
    popin = 16'h0001;
    at_neg();
    check("full_still_blocked", 64'(pop), 64'd0);
    at_pos();
    popin = '0;
    at_neg();
    check("full_fifth_accept", 64'(pop), 64'h0002);
    at_pos();
    popin = 16'h0001;
    repeat (4) at_pos();
    popin = '0;
    at_neg();
    check("full_drained", 64'(pndng), 64'd0);

    // Invalid destination is popped and dropped
    at_pos();
    send(4, 8'h33, pkt);
    at_neg();
    check("inv_pop", 64'(pop), 64'h0010);
    at_neg();
    check("inv_pop_after", 64'(pop), 64'd0);
    at_neg();
    check("inv_no_pndng", 64'(pndng), 64'd0);

    // Asynchronous reset with two packets sitting in FIFO 8
    at_pos();
    send(0, 8'h51, pkt);
    send(0, 8'h51, pkt2);
    at_neg();
    check("rst2_pop_a", 64'(pop), 64'h0001);
    at_neg();
    check("rst2_pop_b", 64'(pop), 64'h0001);
    at_neg();
    check("rst2_pndng", 64'(pndng), 64'h0100);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("rst2_async_pndng", 64'(pndng), 64'd0);
    check("rst2_async_data", 64'(|data_out), 64'd0);
    check("rst2_async_pop", 64'(pop), 64'd0);
    at_pos();
    reset = 1'b0;
    send(0, 8'h02, pkt);
    send(1, 8'h02, pkt2);
    at_neg();
    check("rst2_first_grant", 64'(pop), 64'h0001);
    at_neg();
    check("rst2_second_grant", 64'(pop), 64'h0002);
    at_pos();
    popin = 16'h0002;
    repeat (2) at_pos();
    popin = '0;
    at_neg();
    check("rst2_drained", 64'(pndng), 64'd0);

    // Randomized traffic
    rand_popin = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      at_pos();
      if ($urandom_range(0, 99) < 45) begin
        int s, r;
        logic [7:0] d;
        s = $urandom_range(0, 15);
        r = $urandom_range(0, 99);
        if (r < 70)      d = term_byte($urandom_range(0, 15));
        else if (r < 85) d = 8'hFF;
        else             d = 8'($urandom);
        if (src_q[s].size() < 3) send(s, d, pkt);
      end
    end
    rand_popin = 1'b0;
    at_pos();
    popin = 16'hFFFF;
    cyc = 0;
    while ((sb.size() > 0 || srcs_busy()) && cyc < 1000) begin
      at_pos();
      cyc++;
    end
    check("drain_within_budget", 64'(cyc < 1000), 64'd1);
    repeat (2) at_pos();
    popin = '0;
    at_neg();
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_pndng", 64'(pndng), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
